// File: rtl/lke_pkg.sv
// Shared constants for the lookup-engine action table: control-header
// layout, the control magic flag and the FSM state encodings.
package lke_pkg;

  localparam logic [15:0] CTRL_FLAG     = 16'hf2f1;
  localparam int          HDR_FLAG_LSB  = 320;
  localparam int          HDR_MOD_LSB   = 368;
  localparam int          HDR_RESV_LSB  = 376;
  localparam int          HDR_INDEX_LSB = 384;
  localparam int          PHV_VLAN_LSB  = 129;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_READ = 2'd1,
    D_HOLD = 2'd2
  } data_state_e;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_FWD     = 2'd1,
    C_PAYLOAD = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/lke_act_ram_sdp.sv
// Simple dual-port action RAM: one write port, one registered read port.
// Both ports use non-blocking updates, so a same-cycle read of the address
// being written returns the old contents.
module lke_act_ram_sdp #(
  parameter int WIDTH = 625,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write and one-cycle registered read (read-first ordering).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lke_act_table.sv
// Action table of the lookup engine. Looks up an action for each PHV using
// the match address/hit flag from the matcher, forwards the PHV alongside it,
// and lets the control stream program table entries in place.
module lke_act_table
  import lke_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int LOOKUP_ID            = 2,
  parameter int PHV_LEN              = 1024,
  parameter int ACT_LEN              = 625,
  parameter int ACT_DEPTH            = 16,
  parameter logic [ACT_LEN-1:0] DEFAULT_ACT = 'h3f,
  parameter int C_VLANID_WIDTH       = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PHV_LEN-1:0]                  phv_in,
  input  logic                                phv_valid,
  input  logic [$clog2(ACT_DEPTH)-1:0]        match_addr,
  input  logic                                if_match,
  output logic                                ready_out,
  output logic [ACT_LEN-1:0]                  action,
  output logic                                action_valid,
  output logic [PHV_LEN-1:0]                  phv_out,
  input  logic                                ready_in,
  output logic [C_VLANID_WIDTH-1:0]           act_vlan_out,
  output logic                                act_vlan_out_valid,
  input  logic                                act_vlan_ready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_s_axis_tkeep,
  input  logic                                c_s_axis_tvalid,
  input  logic                                c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int AW    = $clog2(ACT_DEPTH);
  localparam int BEATS = (ACT_LEN + DW - 1) / DW;
  localparam int ACC_W = BEATS * DW;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Payload bytes arrive little-end first; byte 0 lands in the MSB.
  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW/8; i++) r[DW-1-8*i -: 8] = d[8*i +: 8];
    return r;
  endfunction

  data_state_e dstate_q, dstate_d;
  ctrl_state_e cstate_q, cstate_d;

  logic [PHV_LEN-1:0]        phv_lat_q, phv_lat_d;
  logic                      hit_q, hit_d;
  logic [ACT_LEN-1:0]        action_q, action_d;
  logic [PHV_LEN-1:0]        phv_out_q, phv_out_d;
  logic                      action_valid_q, action_valid_d;
  logic [C_VLANID_WIDTH-1:0] vlan_q, vlan_d;
  logic                      vlan_valid_q, vlan_valid_d;

  logic [BCW-1:0]     beat_q, beat_d;
  logic [7:0]         idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [ACT_LEN-1:0] wr_data_q, wr_data_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic [DW-1:0]      m_tdata_q, m_tdata_d;
  logic [UW-1:0]      m_tuser_q, m_tuser_d;
  logic [DW/8-1:0]    m_tkeep_q, m_tkeep_d;

  logic               accept;
  logic [ACT_LEN-1:0] ram_rd_data;
  logic [7:0]         hdr_mod;
  logic [3:0]         hdr_resv;
  logic [15:0]        hdr_flag;
  logic               hdr_own;

  // A new PHV may enter when the data path is free and the VLAN slot drains.
  always_comb begin
    ready_out = rst_n
              && ((dstate_q == D_IDLE) || ((dstate_q == D_HOLD) && ready_in))
              && (!vlan_valid_q || act_vlan_ready);
    accept    = phv_valid && ready_out;
  end

  // Control and output registers (reset), including both FSM states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dstate_q       <= D_IDLE;
      cstate_q       <= C_IDLE;
      action_q       <= '0;
      phv_out_q      <= '0;
      action_valid_q <= 1'b0;
      vlan_q         <= '0;
      vlan_valid_q   <= 1'b0;
      beat_q         <= '0;
      wr_en_q        <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tdata_q      <= '0;
      m_tuser_q      <= '0;
      m_tkeep_q      <= '0;
    end else begin
      dstate_q       <= dstate_d;
      cstate_q       <= cstate_d;
      action_q       <= action_d;
      phv_out_q      <= phv_out_d;
      action_valid_q <= action_valid_d;
      vlan_q         <= vlan_d;
      vlan_valid_q   <= vlan_valid_d;
      beat_q         <= beat_d;
      wr_en_q        <= wr_en_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      m_tdata_q      <= m_tdata_d;
      m_tuser_q      <= m_tuser_d;
      m_tkeep_q      <= m_tkeep_d;
    end
  end

  // Internal data registers; always qualified by the control state above.
  always_ff @(posedge clk) begin
    phv_lat_q <= phv_lat_d;
    hit_q     <= hit_d;
    idx_q     <= idx_d;
    acc_q     <= acc_d;
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

  // Data FSM next state: READ is always exactly one cycle.
  always_comb begin
    dstate_d = dstate_q;
    unique case (dstate_q)
      D_IDLE:  if (accept) dstate_d = D_READ;
      D_READ:  dstate_d = D_HOLD;
      D_HOLD:  if (ready_in) dstate_d = accept ? D_READ : D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  // Data path outputs: latch on accept, capture RAM result in READ.
  always_comb begin
    phv_lat_d      = phv_lat_q;
    hit_d          = hit_q;
    action_d       = action_q;
    phv_out_d      = phv_out_q;
    action_valid_d = action_valid_q;
    vlan_d         = vlan_q;
    vlan_valid_d   = vlan_valid_q;
    if (accept) begin
      phv_lat_d = phv_in;
      hit_d     = if_match;
      vlan_d    = phv_in[PHV_VLAN_LSB +: C_VLANID_WIDTH];
    end
    if (dstate_q == D_READ) begin
      action_d       = hit_q ? ram_rd_data : DEFAULT_ACT;
      phv_out_d      = phv_lat_q;
      action_valid_d = 1'b1;
    end else if ((dstate_q == D_HOLD) && ready_in) begin
      action_valid_d = 1'b0;
    end
    if (accept)                             vlan_valid_d = 1'b1;
    else if (vlan_valid_q && act_vlan_ready) vlan_valid_d = 1'b0;
  end

  // Header decode of the current control beat.
  always_comb begin
    hdr_mod  = c_s_axis_tdata[HDR_MOD_LSB +: 8];
    hdr_resv = c_s_axis_tdata[HDR_RESV_LSB +: 4];
    hdr_flag = c_s_axis_tdata[HDR_FLAG_LSB +: 16];
    hdr_own  = (hdr_mod[7:3] == 5'(STAGE_ID)) && (hdr_mod[2:0] == 3'(LOOKUP_ID))
            && (hdr_flag == CTRL_FLAG) && (hdr_resv != 4'd0);
  end

  // Control FSM next state; only advances on valid beats.
  always_comb begin
    cstate_d = cstate_q;
    if (c_s_axis_tvalid) begin
      unique case (cstate_q)
        C_IDLE: begin
          if (c_s_axis_tlast) cstate_d = C_IDLE;
          else                cstate_d = hdr_own ? C_PAYLOAD : C_FWD;
        end
        C_FWD, C_PAYLOAD: if (c_s_axis_tlast) cstate_d = C_IDLE;
        default: cstate_d = C_IDLE;
      endcase
    end
  end

  // Control outputs: forward foreign beats, assemble and write own entries.
  always_comb begin
    m_tvalid_d = c_s_axis_tvalid
              && (((cstate_q == C_IDLE) && !hdr_own) || (cstate_q == C_FWD));
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tkeep_d  = m_tkeep_q;
    if (m_tvalid_d) begin
      m_tlast_d = c_s_axis_tlast;
      m_tdata_d = c_s_axis_tdata;
      m_tuser_d = c_s_axis_tuser;
      m_tkeep_d = c_s_axis_tkeep;
    end
    beat_d    = beat_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (c_s_axis_tvalid && (cstate_q == C_IDLE) && hdr_own) begin
      idx_d  = c_s_axis_tdata[HDR_INDEX_LSB +: 8];
      beat_d = '0;
    end else if (c_s_axis_tvalid && (cstate_q == C_PAYLOAD)) begin
      acc_d[(BEATS-1-int'(beat_q))*DW +: DW] = byte_swap(c_s_axis_tdata);
      if (beat_q == BCW'(BEATS-1)) begin
        beat_d    = '0;
        idx_d     = idx_q + 8'd1;
        // Out-of-range indices are dropped rather than folded onto low entries.
        wr_en_d   = ({1'b0, idx_q} < 9'(ACT_DEPTH));
        wr_addr_d = idx_q[AW-1:0];
        wr_data_d = acc_d[ACC_W-1 -: ACT_LEN];
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  lke_act_ram_sdp #(
    .WIDTH (ACT_LEN),
    .DEPTH (ACT_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (accept),
    .rd_addr (match_addr),
    .rd_data (ram_rd_data)
  );

  assign action             = action_q;
  assign action_valid       = action_valid_q;
  assign phv_out            = phv_out_q;
  assign act_vlan_out       = vlan_q;
  assign act_vlan_out_valid = vlan_valid_q;
  assign c_m_axis_tdata     = m_tdata_q;
  assign c_m_axis_tuser     = m_tuser_q;
  assign c_m_axis_tkeep     = m_tkeep_q;
  assign c_m_axis_tvalid    = m_tvalid_q;
  assign c_m_axis_tlast     = m_tlast_q;

endmodule
